// File: rtl/npu_pkg.sv
// Shared NPU definitions: op codes, tile lengths and the result-reader state enum.
package npu_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_CONV = 3'd3;
  localparam logic [2:0] OP_DOT  = 3'd4;

  localparam int unsigned DOT_LEN  = 4;
  localparam int unsigned TILE_LEN = 16;
  localparam int unsigned LEN_W    = 5;

  typedef enum logic [2:0] {
    RDR_IDLE,
    RDR_ISSUE,
    RDR_DRAIN,
    RDR_CSUM,
    RDR_FIN
  } rdr_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_beat_t;

  // Number of result bytes produced by an operation.
  function automatic logic [LEN_W-1:0] tile_len(input logic [2:0] op);
    return (op == OP_DOT) ? LEN_W'(DOT_LEN) : LEN_W'(TILE_LEN);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module byte_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign rdata     = mem[rd_ptr];
  assign do_pop_c  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push_c = push && (!full || do_pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

endmodule

// File: rtl/tile_result_reader.sv
// Drains one result tile from SRAM C and streams it out as bytes over valid/ready.
// Optional trailing XOR checksum beat: define TILE_READER_CHECKSUM_EN.
module tile_result_reader
  import npu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        tile_i,
  input  logic [2:0]        op_code,
  input  logic [7:0]        sram_C_dout,
  output logic [ADDR_W-1:0] rd_sram_C_addr,
  output logic              rd_sram_C_en,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  rdr_state_t        state;
  logic [LEN_W-1:0]  k_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;

  fifo_beat_t        wbeat;
  fifo_beat_t        rbeat;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop_c;
  logic [OCC_W-1:0]  occ_next_c;
  logic              issue_ok_c;
  logic              last_k_c;

  assign rd_sram_C_addr = rd_addr_q;
  assign rd_sram_C_en   = rd_en_q;
  assign busy           = busy_q;
  assign done           = done_q;

  assign fifo_pop_c = !fifo_empty && m_ready;
  // Occupancy after this edge, counting the read already in flight as a reserved slot.
  assign occ_next_c = OCC_W'(fifo_count) + OCC_W'(rd_en_q) - OCC_W'(fifo_pop_c);
  assign issue_ok_c = (occ_next_c < OCC_W'(FIFO_DEPTH)) && !(fifo_full && !fifo_pop_c);
  assign last_k_c   = (k_q == len_q - LEN_W'(1));

`ifdef TILE_READER_CHECKSUM_EN
  logic [7:0] cks_q;
  logic       cks_valid_q;

  assign wbeat.last = 1'b0;
  assign wbeat.data = sram_C_dout;
  assign m_valid    = !fifo_empty || cks_valid_q;
  assign m_data     = cks_valid_q ? cks_q : rbeat.data;
  assign m_last     = cks_valid_q;
`else
  logic rd_last_q;

  assign wbeat.last = rd_last_q;
  assign wbeat.data = sram_C_dout;
  assign m_valid    = !fifo_empty;
  assign m_data     = rbeat.data;
  assign m_last     = !fifo_empty && rbeat.last;
`endif

  byte_fifo #(
    .WIDTH ($bits(fifo_beat_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_en_q),
    .wdata (wbeat),
    .pop   (fifo_pop_c),
    .rdata (rbeat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read sequencing FSM with registered SRAM strobe, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RDR_IDLE;
      k_q       <= '0;
      len_q     <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TILE_READER_CHECKSUM_EN
      cks_q       <= '0;
      cks_valid_q <= 1'b0;
`else
      rd_last_q <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef TILE_READER_CHECKSUM_EN
      if (fifo_pop_c) begin
        cks_q <= cks_q ^ rbeat.data;
      end
`endif
      case (state)
        RDR_IDLE: begin
          if (start) begin
            base_q <= (op_code == OP_DOT) ? (ADDR_W'(tile_i) << 5) : (ADDR_W'(tile_i) << 4);
            len_q  <= tile_len(op_code);
            k_q    <= '0;
            busy_q <= 1'b1;
            state  <= RDR_ISSUE;
`ifdef TILE_READER_CHECKSUM_EN
            cks_q  <= '0;
`endif
          end
        end
        RDR_ISSUE: begin
          if (issue_ok_c) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_q + ADDR_W'(k_q);
            k_q       <= k_q + LEN_W'(1);
`ifndef TILE_READER_CHECKSUM_EN
            rd_last_q <= last_k_c;
`endif
            if (last_k_c) begin
              state <= RDR_DRAIN;
            end
          end
        end
        RDR_DRAIN: begin
          // Leave as soon as the final payload pop empties the pipeline.
          if (occ_next_c == '0) begin
`ifdef TILE_READER_CHECKSUM_EN
            cks_valid_q <= 1'b1;
            state       <= RDR_CSUM;
`else
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= RDR_FIN;
`endif
          end
        end
`ifdef TILE_READER_CHECKSUM_EN
        RDR_CSUM: begin
          if (m_ready) begin
            cks_valid_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= RDR_FIN;
          end
        end
`endif
        RDR_FIN: begin
          state <= RDR_IDLE;
        end
        default: begin
          state <= RDR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_result_reader.sv
// Self-checking bench for tile_result_reader (scoreboard of addresses and output beats).
module tb_tile_result_reader;
  import npu_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2;
`ifdef TILE_READER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2:0]        tile_i;
  logic [2:0]        op_code;
  logic [7:0]        sram_C_dout;
  logic [ADDR_W-1:0] rd_sram_C_addr;
  logic              rd_sram_C_en;
  logic              m_valid;
  logic [7:0]        m_data;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic              done;

  logic [7:0] mem [1 << ADDR_W];

  typedef struct { logic [7:0] data; logic last; } beat_t;
  typedef struct {
    logic [2:0] op;
    logic [2:0] tile;
    bit         rnd;
    int         n;
    int         base;
    int         restart_at;
  } vec_t;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  vec_t              vecs[6];

  int checks, errors;
  int cyc, done_cnt, done_cyc, first_valid, issued, popped;
  logic [7:0] last_data;

  tile_result_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tile_i         (tile_i),
    .op_code        (op_code),
    .sram_C_dout    (sram_C_dout),
    .rd_sram_C_addr (rd_sram_C_addr),
    .rd_sram_C_en   (rd_sram_C_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready),
    .busy           (busy),
    .done           (done)
  );

  // SRAM model: data for the presented address is captured by the FIFO on the next edge.
  assign sram_C_dout = mem[rd_sram_C_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input bit rnd);
    bit         xfer;
    bit         stall;
    logic [7:0] d;
    logic       l;
    beat_t      e;
    xfer  = m_valid && m_ready;
    stall = m_valid && !m_ready;
    d     = m_data;
    l     = m_last;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(d), 32'(e.data));
        chk("beat_last", 32'(l), 32'(e.last));
      end
      popped++;
      last_data = d;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (stall) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(d));
      chk("stall_last", 32'(m_last), 32'(l));
    end
    if (rd_sram_C_en) begin
      issued++;
      if (addr_q.size() == 0) chk("extra_read", 32'd1, 32'd0);
      else chk("rd_addr", 32'(rd_sram_C_addr), 32'(addr_q.pop_front()));
    end
    chk("outstanding_ok", 32'((issued - popped) <= int'(DEPTH)), 32'd1);
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic load_expect(input int n, input int base);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      addr_q.push_back(ADDR_W'(base + k));
      exp_q.push_back('{data: mem[ADDR_W'(base + k)], last: (CS == 0) && (k == n - 1)});
      x = x ^ mem[ADDR_W'(base + k)];
    end
    if (CS != 0) exp_q.push_back('{data: x, last: 1'b1});
    first_valid = -1;
    done_cnt    = 0;
    done_cyc    = -1;
    issued      = 0;
    popped      = 0;
  endtask

  task automatic run_txn(input vec_t v);
    load_expect(v.n, v.base);
    op_code = v.op;
    tile_i  = v.tile;
    start   = 1'b1;
    cyc     = -1;
    tick(v.rnd);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      if (cyc == v.restart_at - 1) begin
        start  = 1'b1;
        tile_i = 3'(v.tile + 3'd1);
      end
      tick(v.rnd);
      start = 1'b0;
    end
    if (done_cnt == 0) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("busy_low_at_done", 32'(busy), 32'd0);
      if (!v.rnd) begin
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("done_cycle", 32'(done_cyc), 32'(v.n + 2 + CS));
      end
    end
    m_ready = 1'b1;
    repeat (3) tick(1'b0);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("reads_left", 32'(addr_q.size()), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(m_valid), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(rd_sram_C_addr), 32'd0);
    chk({tag, "_en"}, 32'(rd_sram_C_en), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_data"}, 32'(m_data), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    last_data = 8'h00;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'($urandom);
    mem[224] = 8'h11;
    mem[225] = 8'h22;
    mem[226] = 8'h44;
    mem[227] = 8'h88;

    vecs[0] = '{op: OP_ADD,  tile: 3'd2, rnd: 1'b0, n: 16, base: 32,  restart_at: -1};
    vecs[1] = '{op: OP_DOT,  tile: 3'd7, rnd: 1'b0, n: 4,  base: 224, restart_at: -1};
    vecs[2] = '{op: OP_MUL,  tile: 3'd1, rnd: 1'b1, n: 16, base: 16,  restart_at: -1};
    vecs[3] = '{op: OP_SUB,  tile: 3'd3, rnd: 1'b0, n: 16, base: 48,  restart_at: 5};
    vecs[4] = '{op: OP_CONV, tile: 3'd7, rnd: 1'b0, n: 16, base: 112, restart_at: -1};
    vecs[5] = '{op: OP_DOT,  tile: 3'd0, rnd: 1'b1, n: 4,  base: 0,   restart_at: -1};

    rst_n   = 1'b0;
    start   = 1'b0;
    tile_i  = 3'd0;
    op_code = 3'd0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
`ifdef TILE_READER_CHECKSUM_EN
      if (i == 1) chk("checksum_beat", 32'(last_data), 32'h0000_00FF);
`endif
    end

    // Abort mid-tile: reset once beat 7 is next, then a clean tile 0 read.
    load_expect(16, 32);
    op_code = OP_ADD;
    tile_i  = 3'd2;
    start   = 1'b1;
    cyc     = -1;
    tick(1'b0);
    start = 1'b0;
    for (int i = 0; i < 100 && popped < 7; i++) tick(1'b0);
    chk("reached_beat7", 32'(popped), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    exp_q.delete();
    addr_q.delete();
    repeat (2) tick(1'b0);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk_reset_outputs("post_abort");
    run_txn('{op: OP_ADD, tile: 3'd0, rnd: 1'b0, n: 16, base: 0, restart_at: -1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_result_reader.md
# tile_result_reader

Drains one finished result tile from SRAM C and streams it out as bytes over a valid/ready interface. It is the read-side counterpart of the tile processor's result write-back: it regenerates the same C addresses and reads bytes in the same order they were written. It sits between SRAM C's read port and the host/DMA egress path.

## Interface
- `ADDR_W`, default 10: SRAM C address width.
- `FIFO_DEPTH`, default 2: output buffer entries; legal values are 2 or 4.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. Ignored while `busy`.
- `tile_i`  in  3: result tile index. Sampled when `start` is accepted.
- `op_code`  in  3: operation that produced the tile. Sampled when `start` is accepted.
- `sram_C_dout`  in  8: SRAM C read data. Valid one cycle after the address is presented.
- `rd_sram_C_addr`  out  ADDR_W: SRAM C read address.
- `rd_sram_C_en`  out  1: read strobe, one cycle per issued address.
- `m_valid`  out  1: output byte valid.
- `m_data`  out  8: output byte.
- `m_last`  out  1: marks the final byte of the tile.
- `m_ready`  in  1: downstream accept.
- `busy`  out  1: high from accepted `start` until `done`.
- `done`  out  1: one-cycle pulse after the last byte is accepted.

## Operation
- Op codes: MUL=0, ADD=1, SUB=2, CONV=3, DOT=4.
- Length N:
  - DOT: 4 bytes.
  - All other op codes: 16 bytes.
- Address for byte index k (0..N-1):
  - DOT: `tile_i*32 + k`.
  - Otherwise: `tile_i*16 + k`.
  - Computed at full ADDR_W width with no truncation. Maximum values are 227 (DOT) and 127 (others).
- State machine:
  - IDLE: `start` goes to ISSUE. Latch tile_i, op_code and N; clear k.
  - ISSUE: issue one read per cycle while credit is available. Credit = FIFO occupancy + reads in flight < FIFO_DEPTH. After issuing k=N-1, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to FIN.
  - FIN: pulse `done` for one cycle, drop `busy`, return to IDLE.
- A read issued at cycle t writes `sram_C_dout` into the FIFO at t+1. This reserved slot means the FIFO can never overflow.
- Output is in order. `m_valid` is high whenever the FIFO is non-empty. A beat transfers when `m_valid && m_ready`.
- `m_last` is high only with the beat for byte N-1 (or the checksum beat, see Configuration).
- `m_data`, `m_valid` and `m_last` must hold steady while `m_valid && !m_ready`.
- Simultaneous FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- `start` is ignored in any state other than IDLE.
- `start` in the same cycle as the `done` pulse is ignored, because FIN is not IDLE.
- Reset asserted mid-tile:
  - Aborts immediately; the FIFO is emptied and in-flight data is dropped.
  - No `done` pulse is produced.

## Timing
- Reset values: `rd_sram_C_addr`=0, `rd_sram_C_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0. State is IDLE.
- `start` accepted at cycle 0 → first `rd_sram_C_en` at cycle 1 → first `m_valid` at cycle 2.
- With `m_ready` held high: one byte per cycle. Last beat at cycle N+1, `done` at cycle N+2. Total for a 16-byte tile: `done` 18 cycles after `start`.
- `busy` rises the cycle after `start` is accepted and falls in the same cycle `done` is high.
- When `m_ready` stalls, issue stalls within one cycle, with no loss and no duplication of bytes.

## Configuration
- `TILE_READER_CHECKSUM_EN` defined:
  - Append one extra beat after byte N-1, carrying the XOR of all N payload bytes.
  - `m_last` moves to the checksum beat.
  - The checksum accumulates on pop and resets at `start`.
- Not defined: exactly N beats; no checksum logic is present.

## Structure
- Shared package `npu_pkg`: op-code constants (MUL..DOT), `DOT_LEN`=4, `TILE_LEN`=16, and the reader state enum `rdr_state_t`.
- Sub-module `byte_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, first-word-fall-through output. It is instantiated with WIDTH=9 (data plus last).

## Test plan
- ADD, tile_i=2, `m_ready`=1: addresses 32..47 in order; 16 beats matching SRAM contents; `m_last` on beat 15; `done` 18 cycles after `start`.
- DOT, tile_i=7: addresses 224..227; 4 beats; `m_last` on beat 3; `done` 6 cycles after `start`.
- MUL, tile_i=1, `m_ready` toggling 1-0-0-1 randomly: bytes 16..31 delivered exactly once, in order; `m_data` stable during every stall; no more than FIFO_DEPTH reads outstanding.
- `start` pulsed again at cycle 5 of a 16-byte read: ignored; exactly one `done` pulse.
- `rst_n` low at beat 7 and then released: all outputs return to reset values and no `done` pulse occurs; a new `start` with tile_i=0 then reads 0..15 cleanly.
- With `TILE_READER_CHECKSUM_EN`, DOT tile with bytes 0x11,0x22,0x44,0x88: 5 beats; 5th beat is 0xFF with `m_last` set.
